// File: rtl/pop_eval_pkg.sv
// Shared constants and helpers for the population distance evaluator.
// State encodings plus elaboration-time sizing functions.
package pop_eval_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLaunch = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StStore  = 3'd3;
  localparam logic [2:0] StFinish = 3'd4;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Index widths never collapse to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pop_eval_lane.sv
// Per-individual distance unit: distance is the low genome bits, valid LATENCY cycles
// after the start pulse; done is a level held until the next start.
module pop_eval_lane #(
  parameter int unsigned GENOME_W = 150,
  parameter int unsigned DIST_W   = 12,
  parameter int unsigned LATENCY  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [GENOME_W-1:0] genome_i,
  output logic [DIST_W-1:0]   dist_o,
  output logic                done_o
);

  localparam int unsigned CntW = $clog2(LATENCY + 1);

  logic [CntW-1:0]   cnt_q;
  logic [DIST_W-1:0] dist_q;
  logic              unused_genome;

  assign unused_genome = ^genome_i[GENOME_W-1:DIST_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      dist_q <= '0;
    end else if (start_i) begin
      cnt_q  <= CntW'(LATENCY - 1);
      dist_q <= genome_i[DIST_W-1:0];
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign dist_o = dist_q;
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pop_eval_minsel.sv
// Combinational argmin over the active lanes; lowest lane index wins ties.
module pop_eval_minsel #(
  parameter int unsigned LANES  = 10,
  parameter int unsigned DIST_W = 12,
  parameter int unsigned LIDX_W = 4
) (
  input  logic [LANES*DIST_W-1:0] dist_i,
  input  logic [LANES-1:0]        active_i,
  output logic [DIST_W-1:0]       min_o,
  output logic [LIDX_W-1:0]       idx_o,
  output logic                    valid_o
);

  logic [DIST_W-1:0] min_d;
  logic [LIDX_W-1:0] idx_d;
  logic              valid_d;

  always_comb begin
    min_d   = '1;
    idx_d   = '0;
    valid_d = 1'b0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (active_i[l] && (!valid_d || (dist_i[l*DIST_W +: DIST_W] < min_d))) begin
        min_d   = dist_i[l*DIST_W +: DIST_W];
        idx_d   = LIDX_W'(l);
        valid_d = 1'b1;
      end
    end
  end

  assign min_o   = min_d;
  assign idx_o   = idx_d;
  assign valid_o = valid_d;

endmodule

// File: rtl/pop_distance_eval.sv
// Time-multiplexed population distance evaluator: streams POP_SIZE genomes through
// LANES distance units in batches, collecting every distance and the overall argmin.
module pop_distance_eval
  import pop_eval_pkg::*;
#(
  parameter int unsigned POP_SIZE     = 50,
  parameter int unsigned GENOME_W     = 150,
  parameter int unsigned DIST_W       = 12,
  parameter int unsigned LANES        = 10,
  parameter int unsigned LANE_LATENCY = 4,
  parameter int unsigned IDX_W        = clog2_min1(POP_SIZE)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [POP_SIZE*GENOME_W-1:0] pop_i,
  output logic [POP_SIZE*DIST_W-1:0]   distances_o,
  output logic [DIST_W-1:0]            best_dist_o,
  output logic [IDX_W-1:0]             best_idx_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int unsigned NB     = ceil_div(POP_SIZE, LANES);
  localparam int unsigned BW     = clog2_min1(NB);
  localparam int unsigned LIDX_W = clog2_min1(LANES);

  logic [2:0]                   state_q, state_d;
  logic [BW-1:0]                batch_q, batch_d;
  logic [POP_SIZE*GENOME_W-1:0] pop_q;
  logic [POP_SIZE*DIST_W-1:0]   dist_q;
  logic [DIST_W-1:0]            best_dist_q;
  logic [IDX_W-1:0]             best_idx_q;
  logic                         best_valid_q;

  logic [LANES-1:0]          active, lane_done;
  logic [LANES*GENOME_W-1:0] lane_genome;
  logic [LANES*DIST_W-1:0]   lane_dist;
  logic                      lane_start, all_done, in_store, take_best;
  logic [DIST_W-1:0]         sel_min;
  logic [LIDX_W-1:0]         sel_lidx;
  logic                      sel_valid;

  function automatic int slot(input logic [BW-1:0] b, input int l);
    return int'(b) * int'(LANES) + l;
  endfunction

  // Lanes past the end of the population see a zero genome and are masked out.
  always_comb begin
    active      = '0;
    lane_genome = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (slot(batch_q, l) < int'(POP_SIZE)) begin
        active[l] = 1'b1;
        lane_genome[l*GENOME_W +: GENOME_W] = pop_q[slot(batch_q, l)*GENOME_W +: GENOME_W];
      end
    end
  end

  assign lane_start = (state_q == StLaunch);
  assign all_done   = &(lane_done | ~active);
  assign in_store   = (state_q == StStore);

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    pop_eval_lane #(
      .GENOME_W(GENOME_W),
      .DIST_W  (DIST_W),
      .LATENCY (LANE_LATENCY)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (lane_start),
      .genome_i(lane_genome[g*GENOME_W +: GENOME_W]),
      .dist_o  (lane_dist[g*DIST_W +: DIST_W]),
      .done_o  (lane_done[g])
    );
  end

  pop_eval_minsel #(
    .LANES (LANES),
    .DIST_W(DIST_W),
    .LIDX_W(LIDX_W)
  ) u_minsel (
    .dist_i  (lane_dist),
    .active_i(active),
    .min_o   (sel_min),
    .idx_o   (sel_lidx),
    .valid_o (sel_valid)
  );

  // Later batches hold higher indices, so strict-less keeps the lowest index on ties.
  assign take_best = in_store && sel_valid && (!best_valid_q || (sel_min < best_dist_q));

  always_comb begin
    state_d = state_q;
    batch_d = batch_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLaunch;
          batch_d = '0;
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (all_done) state_d = StStore;
      end
      StStore: begin
        if (batch_q == BW'(NB - 1)) begin
          state_d = StFinish;
        end else begin
          batch_d = batch_q + 1'b1;
          state_d = StLaunch;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      batch_q      <= '0;
      pop_q        <= '0;
      dist_q       <= '0;
      best_dist_q  <= '0;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      batch_q <= batch_d;
      if (state_q == StIdle && start_i) begin
        pop_q        <= pop_i;
        best_dist_q  <= '1;
        best_idx_q   <= '0;
        best_valid_q <= 1'b0;
      end
      if (in_store) begin
        for (int l = 0; l < int'(LANES); l++) begin
          if (active[l]) begin
            dist_q[slot(batch_q, l)*DIST_W +: DIST_W] <= lane_dist[l*DIST_W +: DIST_W];
          end
        end
      end
      if (take_best) begin
        best_dist_q  <= sel_min;
        best_idx_q   <= IDX_W'(slot(batch_q, int'(sel_lidx)));
        best_valid_q <= 1'b1;
      end
    end
  end

  assign distances_o = dist_q;
  assign best_dist_o = best_dist_q;
  assign best_idx_o  = best_idx_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StFinish);

endmodule

// File: tb/tb_pop_distance_eval.sv
// Bench for pop_distance_eval: three lane counts (10, 8, 50) over a 50-genome population,
// table-driven runs plus hand-written busy, back-to-back and mid-run reset sequences.
module tb_pop_distance_eval;

  localparam int P  = 50;
  localparam int G  = 150;
  localparam int D  = 12;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [P*G-1:0] pop = '0;
  logic [2:0] start = '0;

  logic [P*D-1:0] dist_o [3];
  logic [D-1:0]   bd_o   [3];
  logic [IW-1:0]  bi_o   [3];
  logic           busy_o [3];
  logic           done_o [3];

  logic [G-1:0] snap [P];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pop_distance_eval #(.POP_SIZE(P), .GENOME_W(G), .DIST_W(D), .LANES(10)) u_l10 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .pop_i(pop),
    .distances_o(dist_o[0]), .best_dist_o(bd_o[0]), .best_idx_o(bi_o[0]),
    .busy_o(busy_o[0]), .done_o(done_o[0])
  );
  pop_distance_eval #(.POP_SIZE(P), .GENOME_W(G), .DIST_W(D), .LANES(8)) u_l8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .pop_i(pop),
    .distances_o(dist_o[1]), .best_dist_o(bd_o[1]), .best_idx_o(bi_o[1]),
    .busy_o(busy_o[1]), .done_o(done_o[1])
  );
  pop_distance_eval #(.POP_SIZE(P), .GENOME_W(G), .DIST_W(D), .LANES(50)) u_l50 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .pop_i(pop),
    .distances_o(dist_o[2]), .best_dist_o(bd_o[2]), .best_idx_o(bi_o[2]),
    .busy_o(busy_o[2]), .done_o(done_o[2])
  );

  typedef struct {
    int sel;
    int kind;
    int lat;
    int bidx;
    int bdist;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // kind 0: 1000-i, 1: ties at 2/17/33, 2: all max, 3: random; upper genome bits are noise.
  task automatic set_pattern(input int kind);
    logic [159:0] r;
    logic [G-1:0] g;
    for (int i = 0; i < P; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      g = r[G-1:0];
      case (kind)
        0:       g[D-1:0] = D'(1000 - i);
        1:       g[D-1:0] = (i == 2 || i == 17 || i == 33) ? D'(5) : D'(100);
        2:       g[D-1:0] = '1;
        default: g[D-1:0] = D'($urandom_range(0, 4095));
      endcase
      pop[i*G +: G] = g;
    end
  endtask

  task automatic take_snapshot();
    for (int i = 0; i < P; i++) snap[i] = pop[i*G +: G];
  endtask

  task automatic check_results(input int s, input string tag);
    int bad = 0;
    int bix = 0;
    int bdv = int'(snap[0][D-1:0]);
    for (int i = 0; i < P; i++) begin
      if (dist_o[s][i*D +: D] !== snap[i][D-1:0]) bad++;
      if (int'(snap[i][D-1:0]) < bdv) begin
        bdv = int'(snap[i][D-1:0]);
        bix = i;
      end
    end
    check({tag, "_dist_slots_wrong"}, 64'(bad), 64'(0));
    check({tag, "_best_dist"}, 64'(bd_o[s]), 64'(bdv));
    check({tag, "_best_idx"}, 64'(bi_o[s]), 64'(bix));
  endtask

  // Start pulse sampled in cycle 0; returns in the done cycle, after result checks.
  task automatic run(input int s, input int exp_lat, input string tag);
    int n = 1;
    int busy_bad = 0;
    bit got = 0;
    @(negedge clk);
    start[s] = 1'b1;
    take_snapshot();
    @(posedge clk);
    #1;
    start[s] = 1'b0;
    pop = ~pop;  // post-acceptance changes must not matter
    while (n < 400 && !got) begin
      @(negedge clk);
      if (busy_o[s] !== 1'b1) busy_bad++;
      if (done_o[s] === 1'b1) got = 1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check({tag, "_done_cycle"}, got ? 64'(n) : 64'(-1), 64'(exp_lat));
    check({tag, "_busy_during_run"}, 64'(busy_bad), 64'(0));
    check_results(s, tag);
  endtask

  task automatic post_idle(input int s, input string tag);
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy_o[s]), 64'(0));
    check({tag, "_done_after"}, 64'(done_o[s]), 64'(0));
  endtask

  task automatic check_zero(input int s, input string tag);
    check({tag, "_dist_zero"}, 64'(dist_o[s] == '0), 64'(1));
    check({tag, "_best_dist_zero"}, 64'(bd_o[s]), 64'(0));
    check({tag, "_best_idx_zero"}, 64'(bi_o[s]), 64'(0));
    check({tag, "_busy_zero"}, 64'(busy_o[s]), 64'(0));
    check({tag, "_done_zero"}, 64'(done_o[s]), 64'(0));
  endtask

  initial begin
    vec_t vecs [11];
    int ndone;
    int first;
    int n;

    vecs[0]  = '{0, 0, 31, 49, 951};
    vecs[1]  = '{1, 0, 43, 49, 951};
    vecs[2]  = '{2, 0, 7, 49, 951};
    vecs[3]  = '{0, 1, 31, 2, 5};
    vecs[4]  = '{1, 1, 43, 2, 5};
    vecs[5]  = '{0, 2, 31, 0, 4095};
    vecs[6]  = '{2, 2, 7, 0, 4095};
    vecs[7]  = '{0, 3, 31, -1, -1};
    vecs[8]  = '{1, 3, 43, -1, -1};
    vecs[9]  = '{2, 3, 7, -1, -1};
    vecs[10] = '{1, 2, 43, 0, 4095};

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) check_zero(s, $sformatf("reset_s%0d", s));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) check_zero(s, $sformatf("idle_s%0d", s));

    for (int v = 0; v < 11; v++) begin
      string tag = $sformatf("vec%0d", v);
      set_pattern(vecs[v].kind);
      run(vecs[v].sel, vecs[v].lat, tag);
      if (vecs[v].bidx >= 0) begin
        check({tag, "_tbl_best_idx"}, 64'(bi_o[vecs[v].sel]), 64'(vecs[v].bidx));
        check({tag, "_tbl_best_dist"}, 64'(bd_o[vecs[v].sel]), 64'(vecs[v].bdist));
      end
      if (vecs[v].kind == 0)
        check({tag, "_slot0"}, 64'(dist_o[vecs[v].sel][D-1:0]), 64'(1000));
      post_idle(vecs[v].sel, tag);
    end

    // Start held through cycles 0..31 yields exactly one run.
    set_pattern(3);
    @(negedge clk);
    start[0] = 1'b1;
    take_snapshot();
    ndone = 0;
    first = -1;
    n = 0;
    repeat (80) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 32) start[0] = 1'b0;
      @(negedge clk);
      if (done_o[0] === 1'b1) begin
        ndone++;
        if (first < 0) first = n;
      end
    end
    check("hold_done_count", 64'(ndone), 64'(1));
    check("hold_done_cycle", 64'(first), 64'(31));
    check_results(0, "hold");

    // Back-to-back: second start in the cycle right after done.
    set_pattern(3);
    run(0, 31, "b2b_a");
    set_pattern(0);
    run(0, 31, "b2b_b");
    post_idle(0, "b2b");

    // Reset during batch 3 (LAUNCH of batch 3 is cycle 19).
    set_pattern(3);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy_o[0]), 64'(1));
    rst_n = 1'b0;
    #1;
    check_zero(0, "midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_pattern(3);
    run(0, 31, "post_rst");
    post_idle(0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
